// File: rtl/heap_pkg.sv
// Shared types and helpers for the top-K min-heap sift pipeline.
// Words carry an unsigned key in their top bits; the remaining bits are payload.
package heap_pkg;

  localparam int HEAP_KEY_WIDTH = 16;
  // Widest node word the key helper accepts.
  localparam int HEAP_MAX_DW    = 64;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    CMP  = 2'd2
  } state_t;

  // Caller zero-extends the word to HEAP_MAX_DW and truncates the result to kw bits.
  function automatic logic [HEAP_MAX_DW-1:0] key_of(
    input logic [HEAP_MAX_DW-1:0] word,
    input int                     dw,
    input int                     kw
  );
    return word >> (dw - kw);
  endfunction

  // Child node index at the next level: left child sel=0, right child sel=1.
  function automatic logic [32:0] child_idx(
    input logic [31:0] idx,
    input logic        sel
  );
    return {idx, sel};
  endfunction

endpackage

// File: rtl/heap_min2.sv
// Combinational min of two node words by key; zero latency, no flow control.
// A tie selects the left word (sel=0) so equal keys never move needlessly.
module heap_min2
  import heap_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int KEY_WIDTH  = HEAP_KEY_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] min_word,
  output logic                  sel
);

  logic [KEY_WIDTH-1:0] key_a;
  logic [KEY_WIDTH-1:0] key_b;

  assign key_a    = KEY_WIDTH'(key_of(HEAP_MAX_DW'(a), DATA_WIDTH, KEY_WIDTH));
  assign key_b    = KEY_WIDTH'(key_of(HEAP_MAX_DW'(b), DATA_WIDTH, KEY_WIDTH));
  assign sel      = key_b < key_a;
  assign min_word = sel ? b : a;

endmodule

// File: rtl/heap_sift_stage.sv
// One heap level: zero-fills its own level, then places V at node i, swapping with the smaller child.
// Accept cycle t, own write and child request decided in t+1, out_valid in t+2; in_ready low from t+1 to t+2.
module heap_sift_stage
  import heap_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int KEY_WIDTH  = HEAP_KEY_WIDTH,
  parameter int LEVEL      = 1,
  parameter bit IS_LAST    = 1'b0,
  parameter int IW         = (LEVEL > 1) ? LEVEL : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [IW-1:0]         in_idx,
  input  logic [DATA_WIDTH-1:0] in_val,
  output logic                  in_ready,
  output logic [IW:0]           ch_addr_a,
  output logic [IW:0]           ch_addr_b,
  input  logic [DATA_WIDTH-1:0] ch_q_a,
  input  logic [DATA_WIDTH-1:0] ch_q_b,
  output logic                  wr_en,
  output logic [IW-1:0]         wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  out_valid,
  output logic [IW:0]           out_idx,
  output logic [DATA_WIDTH-1:0] out_val,
  output logic                  init_done
);

  localparam int           CW    = IW + 1;
  localparam logic [CW-1:0] NODES = CW'(1) << LEVEL;

  typedef struct packed {
    logic [IW-1:0]         idx;
    logic [DATA_WIDTH-1:0] val;
  } req_t;

  state_t                state;
  logic [CW-1:0]         init_cnt;
  logic                  init_wr_q;
  logic [IW-1:0]         init_addr_q;
  req_t                  req_q;
  logic [DATA_WIDTH-1:0] min_word;
  logic                  min_sel;
  logic [KEY_WIDTH-1:0]  v_key;
  logic [KEY_WIDTH-1:0]  m_key;
  logic                  sift_stop;

  // Child reads are issued in the accept cycle so the words land in CMP.
  assign ch_addr_a = {in_idx, 1'b0};
  assign ch_addr_b = {in_idx, 1'b1};

  heap_min2 #(
    .DATA_WIDTH (DATA_WIDTH),
    .KEY_WIDTH  (KEY_WIDTH)
  ) u_min2 (
    .a        (ch_q_a),
    .b        (ch_q_b),
    .min_word (min_word),
    .sel      (min_sel)
  );

  assign v_key     = KEY_WIDTH'(key_of(HEAP_MAX_DW'(req_q.val), DATA_WIDTH, KEY_WIDTH));
  assign m_key     = KEY_WIDTH'(key_of(HEAP_MAX_DW'(min_word), DATA_WIDTH, KEY_WIDTH));
  assign sift_stop = IS_LAST || (v_key <= m_key);

  // The CMP write depends on the child words, which are only valid in that cycle.
  always_comb begin
    wr_en   = init_wr_q;
    wr_addr = init_addr_q;
    wr_data = '0;
    if (state == CMP) begin
      wr_en   = 1'b1;
      wr_addr = req_q.idx;
      wr_data = sift_stop ? req_q.val : min_word;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= INIT;
      init_cnt    <= '0;
      init_wr_q   <= 1'b0;
      init_addr_q <= '0;
      req_q       <= '0;
      in_ready    <= 1'b0;
      init_done   <= 1'b0;
      out_valid   <= 1'b0;
      out_idx     <= '0;
      out_val     <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        INIT: begin
          if (init_cnt == NODES) begin
            init_wr_q <= 1'b0;
            init_done <= 1'b1;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end else begin
            init_wr_q   <= 1'b1;
            init_addr_q <= IW'(init_cnt);
            init_cnt    <= init_cnt + CW'(1);
          end
        end
        IDLE: begin
          if (in_valid && in_ready) begin
            req_q    <= '{idx: in_idx, val: in_val};
            in_ready <= 1'b0;
            state    <= CMP;
          end
        end
        CMP: begin
          in_ready <= 1'b1;
          state    <= IDLE;
          if (!sift_stop) begin
            out_valid <= 1'b1;
            out_idx   <= CW'(child_idx(32'(req_q.idx), min_sel));
            out_val   <= req_q.val;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  a_in_protocol: assert property (@(posedge clk) disable iff (!rst_n) in_valid |-> in_ready);

endmodule
